// File: rtl/regfile_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Two-requester (ALU / load unit) writeback arbiter in front of
//               a single register-file write port, with a per-register
//               pending-write scoreboard. Round-robin between the ALU and the
//               load unit, favouring the ALU after reset. Defining the macro
//               RF_ARB_FIXED_PRIO_EN makes the load unit always win a
//               contested cycle and removes the round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  // ALU writeback requester
  input  logic                                   alu_valid,
  input  logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] alu_reg,
  input  logic [DATA_W-1:0]                      alu_data,
  output logic                                   alu_ready,
  // Load-unit writeback requester
  input  logic                                   mem_valid,
  input  logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] mem_reg,
  input  logic [DATA_W-1:0]                      mem_data,
  output logic                                   mem_ready,
  // Decode-stage destination reservation
  input  logic                                   rsv_valid,
  input  logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] rsv_reg,
  // Register-file write port
  output logic                                   WriteEnable,
  output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] WriteReg,
  output logic [DATA_W-1:0]                      WriteData,
  // Pending-write scoreboard
  output logic [NUM_REGS-1:0]                    busy
);

  localparam int c_REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Grant encoding: which requester wins the write port this cycle
  localparam logic [1:0] c_GRANT_NONE = 2'b00;
  localparam logic [1:0] c_GRANT_ALU  = 2'b01;
  localparam logic [1:0] c_GRANT_MEM  = 2'b10;

  logic [1:0]          w_grant;
  logic                w_anyGrant;
  logic [c_REG_W-1:0]  w_selReg;
  logic [DATA_W-1:0]   w_selData;
  logic [NUM_REGS-1:0] w_setMask;
  logic [NUM_REGS-1:0] w_clrMask;

  logic                r_writeEnable;
  logic [c_REG_W-1:0]  r_writeReg;
  logic [DATA_W-1:0]   r_writeData;
  logic [NUM_REGS-1:0] r_busy;

`ifndef RF_ARB_FIXED_PRIO_EN
  // Round-robin pointer: a one-bit state machine naming the requester that
  // wins the next contested cycle.
  localparam logic [0:0] c_FAV_ALU = 1'b0;
  localparam logic [0:0] c_FAV_MEM = 1'b1;

  logic [0:0] r_favour;

  // Pointer moves only on a grant, always towards the requester not served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_favour <= c_FAV_ALU;
    end else if (w_grant == c_GRANT_ALU) begin
      r_favour <= c_FAV_MEM;
    end else if (w_grant == c_GRANT_MEM) begin
      r_favour <= c_FAV_ALU;
    end
  end
`endif

  // Grant decision; nothing is granted while reset is held low
  always_comb begin
    w_grant = c_GRANT_NONE;
    if (rst_n) begin
      if (alu_valid && mem_valid) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        w_grant = c_GRANT_MEM;
`else
        w_grant = (r_favour == c_FAV_MEM) ? c_GRANT_MEM : c_GRANT_ALU;
`endif
      end else if (alu_valid) begin
        w_grant = c_GRANT_ALU;
      end else if (mem_valid) begin
        w_grant = c_GRANT_MEM;
      end
    end
  end

  assign alu_ready  = (w_grant == c_GRANT_ALU);
  assign mem_ready  = (w_grant == c_GRANT_MEM);
  assign w_anyGrant = (w_grant != c_GRANT_NONE);

  // Select the winning requester's destination and data
  always_comb begin
    w_selReg  = alu_reg;
    w_selData = alu_data;
    if (w_grant == c_GRANT_MEM) begin
      w_selReg  = mem_reg;
      w_selData = mem_data;
    end
  end

  // Per-register set (reservation) and clear (accepted write) decode
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_busyDec
    localparam logic [c_REG_W-1:0] c_IDX = c_REG_W'(i);
    assign w_setMask[i] = rsv_valid  && (rsv_reg  == c_IDX);
    assign w_clrMask[i] = w_anyGrant && (w_selReg == c_IDX);
  end

  // Scoreboard: a reservation wins over a same-cycle clear, no counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clrMask) | w_setMask;
    end
  end

  // Write port: strobe for exactly one cycle after a grant, index/data hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_writeEnable <= 1'b0;
      r_writeReg    <= '0;
      r_writeData   <= '0;
    end else begin
      r_writeEnable <= w_anyGrant;
      if (w_anyGrant) begin
        r_writeReg  <= w_selReg;
        r_writeData <= w_selData;
      end
    end
  end

  assign WriteEnable = r_writeEnable;
  assign WriteReg    = r_writeReg;
  assign WriteData   = r_writeData;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Scoreboard bench for regfile_wr_arbiter. Directed scenarios
//               followed by random traffic, checked against a behavioural
//               model of the arbitration rules and busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_valid, mem_valid, rsv_valid;
  logic [1:0] alu_reg, mem_reg, rsv_reg;
  logic [7:0] alu_data, mem_data;
  logic       alu_ready, mem_ready;
  logic       WriteEnable;
  logic [1:0] WriteReg;
  logic [7:0] WriteData;
  logic [3:0] busy;

  regfile_wr_arbiter #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .WriteEnable(WriteEnable), .WriteReg(WriteReg), .WriteData(WriteData), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] r;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   monOn  = 0;

  // Reference model state
  logic [3:0] mBusy     = '0;
  bit         mFavMem   = 0;   // round-robin: next contested cycle goes to mem
  logic [1:0] mLastReg  = '0;
  logic [7:0] mLastData = '0;
  bit         accA = 0, accM = 0;
  logic       rdyA, rdyM;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // One arbitration cycle: predict grant at the negedge, record expected write,
  // advance the model after the edge.
  task automatic step();
    bit gA, gM;
    logic [3:0] nb;
    @(negedge clk);
    gA = 0; gM = 0;
    if (alu_valid && mem_valid) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      gM = 1;
`else
      if (mFavMem) gM = 1; else gA = 1;
`endif
    end else if (alu_valid) gA = 1;
    else if (mem_valid) gM = 1;
    rdyA = alu_ready;
    rdyM = mem_ready;
    check("alu_ready", alu_ready, gA);
    check("mem_ready", mem_ready, gM);
    nb = mBusy;
    if (gA) begin nb[alu_reg] = 1'b0; q.push_back('{cyc + 1, alu_reg, alu_data}); end
    if (gM) begin nb[mem_reg] = 1'b0; q.push_back('{cyc + 1, mem_reg, mem_data}); end
    if (rsv_valid) nb[rsv_reg] = 1'b1;
    @(posedge clk); #1;
    mBusy = nb;
    if (gA) mFavMem = 1;
    else if (gM) mFavMem = 0;
    accA = gA; accM = gM;
  endtask

  // Monitor: every strobe must match the oldest expected write in its cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && monOn) begin
      check("busy", busy, mBusy);
      if (WriteEnable) begin
        if (q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = q.pop_front();
          check("write_cycle", cyc, e.cyc);
          check("WriteReg", WriteReg, e.r);
          check("WriteData", WriteData, e.d);
          mLastReg  = e.r;
          mLastData = e.d;
        end
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          check("missing_write", 0, 1);
          void'(q.pop_front());
        end
        check("hold_WriteReg", WriteReg, mLastReg);
        check("hold_WriteData", WriteData, mLastData);
      end
    end
  end

  task automatic idleInputs();
    alu_valid = 0; mem_valid = 0; rsv_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    alu_valid = 1; alu_reg = 2'd1; alu_data = 8'h12;
    mem_valid = 1; mem_reg = 2'd2; mem_data = 8'h34;
    rsv_valid = 0; rsv_reg = 2'd0;

    // Reset state, readies held low while in reset
    #3;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_WriteEnable", WriteEnable, 0);
    check("rst_WriteReg", WriteReg, 0);
    check("rst_WriteData", WriteData, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    idleInputs();
    rst_n = 1;
    monOn = 1;

    // Single ALU write after reset
    alu_valid = 1; alu_reg = 2'd1; alu_data = 8'h55;
    step();
    check("d1_alu_ready", rdyA, 1);
    check("d1_WriteEnable", WriteEnable, 1);
    check("d1_WriteReg", WriteReg, 1);
    check("d1_WriteData", WriteData, 8'h55);
    idleInputs();

    // Reserve r3, then a load write to r3 clears it
    rsv_valid = 1; rsv_reg = 2'd3;
    step();
    check("d3_busy_set", busy, 4'b1000);
    rsv_valid = 0;
    mem_valid = 1; mem_reg = 2'd3; mem_data = 8'h3C;
    step();
    check("d3_busy_clr", busy, 4'b0000);
    idleInputs();

    // Contention for 4 cycles; last grant was mem so ALU goes first
    alu_valid = 1; alu_reg = 2'd0; alu_data = 8'hAA;
    mem_valid = 1; mem_reg = 2'd2; mem_data = 8'h0F;
    for (int k = 0; k < 4; k++) begin
      step();
`ifdef RF_ARB_FIXED_PRIO_EN
      check("d2_seq_mem", rdyM, 1);
`else
      check("d2_seq_mem", rdyM, (k % 2 == 1) ? 1 : 0);
      check("d2_seq_alu", rdyA, (k % 2 == 0) ? 1 : 0);
`endif
    end
    idleInputs();

    // Reservation and grant to r2 in the same cycle: set wins
    alu_valid = 1; alu_reg = 2'd2; alu_data = 8'hC3;
    rsv_valid = 1; rsv_reg = 2'd2;
    step();
    check("d4_busy2", busy[2], 1);
    idleInputs();

    // Idle cycles: no strobe, outputs hold, pointer unchanged
    repeat (3) begin
      step();
      check("d6_WriteEnable", WriteEnable, 0);
    end
    check("d6_WriteReg", WriteReg, 2'd2);
    check("d6_WriteData", WriteData, 8'hC3);
    alu_valid = 1; alu_reg = 2'd1; alu_data = 8'h11;
    mem_valid = 1; mem_reg = 2'd0; mem_data = 8'h22;
    step();
    check("d6_ptr_mem", rdyM, 1);
    mem_valid = 0;
    step();
    idleInputs();

    // Reset pulse while a write strobe is pending
    alu_valid = 1; alu_reg = 2'd1; alu_data = 8'h77;
    step();
    check("d5_pending", WriteEnable, 1);
    idleInputs();
    #1 rst_n = 0;
    #0.5;
    check("d5_WriteEnable", WriteEnable, 0);
    check("d5_busy", busy, 4'b0000);
    q.delete();
    mBusy = '0; mFavMem = 0; mLastReg = '0; mLastData = '0;
    #0.5 rst_n = 1;
    repeat (2) step();

    // Random traffic; requesters hold reg/data until accepted
    accA = 0; accM = 0;
    for (int n = 0; n < 300; n++) begin
      if (!alu_valid || accA) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_reg   = 2'($urandom_range(0, 3));
        alu_data  = 8'($urandom_range(0, 255));
      end
      if (!mem_valid || accM) begin
        mem_valid = ($urandom_range(0, 9) < 6);
        mem_reg   = 2'($urandom_range(0, 3));
        mem_data  = 8'($urandom_range(0, 255));
      end
      rsv_valid = ($urandom_range(0, 9) < 3);
      rsv_reg   = 2'($urandom_range(0, 3));
      step();
    end
    idleInputs();
    repeat (3) step();
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 8, write data width.
REQ-002 SHALL have parameter: NUM_REGS, 4, register count; register index width is 2.
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: alu_valid  input  1  ALU writeback request.
REQ-006 SHALL have port: alu_reg  input  2  ALU destination register.
REQ-007 SHALL have port: alu_data  input  8  ALU result.
REQ-008 SHALL have port: alu_ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port: mem_valid  input  1  load-unit writeback request.
REQ-010 SHALL have port: mem_reg  input  2  load destination register.
REQ-011 SHALL have port: mem_data  input  8  load data.
REQ-012 SHALL have port: mem_ready  output  1  load request accepted this cycle.
REQ-013 SHALL have port: rsv_valid  input  1  decode reserves a destination register.
REQ-014 SHALL have port: rsv_reg  input  2  register being reserved.
REQ-015 SHALL have port: WriteEnable  output  1  register-file write strobe.
REQ-016 SHALL have port: WriteReg  output  2  register-file write index.
REQ-017 SHALL have port: WriteData  output  8  register-file write data.
REQ-018 SHALL have port: busy  output  4  per-register pending-write scoreboard.

Function
REQ-019 SHALL accept a requester when valid and ready are both high in the same cycle; the requester holds reg/data stable until accepted.
REQ-020 SHALL assert at most one of alu_ready/mem_ready per cycle; ready is combinational from valid and the priority pointer.
REQ-021 SHALL grant the only valid requester when one is valid; with both valid, SHALL grant the one not granted last (round-robin), with ALU favoured after reset.
REQ-022 SHALL update the priority pointer only on a grant; idle cycles leave it unchanged.
REQ-023 SHALL register the accepted reg/data and drive WriteEnable high for exactly the next cycle, giving 1-cycle latency and 1 write/cycle throughput.
REQ-024 SHALL hold WriteReg/WriteData at their last values and WriteEnable low when no grant occurred in the previous cycle.
REQ-025 SHALL set busy[rsv_reg] on the edge where rsv_valid is high.
REQ-026 SHALL clear busy[r] on the edge where a grant to register r is accepted.
REQ-027 SHALL give set priority over clear when a reservation and a grant target the same register in the same cycle; the result is busy=1.
REQ-028 SHALL leave busy unchanged for a reservation of an already-busy register, with no counting; one write clears it.
REQ-029 SHALL still perform the write and leave busy[r]=0 for a grant to a non-busy register.

Reset
REQ-030 SHALL, on rst_n low and asynchronously, force WriteEnable=0, WriteReg=0, WriteData=0, busy=0 and the pointer to ALU-favoured.
REQ-031 SHALL drop any request in flight when reset asserts mid-operation; no write strobe appears after release until a new grant.
REQ-032 SHALL drive alu_ready=mem_ready=0 while rst_n is low.

Configuration
REQ-033 SHALL provide macro RF_ARB_FIXED_PRIO_EN; when defined, mem always wins a contested cycle and the pointer is removed; when undefined, REQ-021 round-robin applies.

Verification
REQ-034 SHALL verify: after reset, alu_valid=1, alu_reg=1, alu_data=8'h55 -> alu_ready=1 same cycle; next cycle WriteEnable=1, WriteReg=1, WriteData=8'h55.
REQ-035 SHALL verify: both valid for 4 cycles (alu r0=8'hAA, mem r2=8'h0F) -> grants alternate ALU, MEM, ALU, MEM (MEM every cycle if RF_ARB_FIXED_PRIO_EN).
REQ-036 SHALL verify: rsv_valid with rsv_reg=3 -> busy=4'b1000; mem write to r3 accepted -> busy=4'b0000 on the following cycle.
REQ-037 SHALL verify: same cycle rsv_reg=2 and ALU grant to r2 -> busy[2]=1 after the edge.
REQ-038 SHALL verify: rst_n pulled low for 1 ns while a grant is pending -> WriteEnable=0, busy=0 immediately; no write strobe after release.
REQ-039 SHALL verify: no valids for 3 cycles -> WriteEnable stays 0, WriteReg/WriteData hold their last values, and the pointer is unchanged.
